adc_avg_hold: RTL

//  Upstream feeder of the 14-bit binary-to-7-segment decimal display stage. Averages a

---
 rtl/adc_disp_pkg.sv | 10 +
 rtl/hold_timer.sv | 22 ++
 rtl/adc_avg_hold.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adc_disp_pkg.sv
// Shared types and widths for the ADC averaging / decimal display path.
package adc_disp_pkg;

  localparam int unsigned ADC_DATA_W = 14;

  typedef enum logic {ACCUM, HOLD} avg_state_t;

  typedef logic [ADC_DATA_W-1:0] adc_code_t;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module hold_timer #(
  parameter int unsigned W = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)               count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/adc_avg_hold.sv
// Averages windows of 2^LOG2_N ADC samples and holds each result for HOLD_CYCLES.
// Optional AVG_PEAK_HOLD_EN adds peak_out, the max sample of the displayed window.
module adc_avg_hold
  import adc_disp_pkg::*;
#(
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned LOG2_N      = 4,
  parameter int unsigned HOLD_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              freeze,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              overrange
`ifdef AVG_PEAK_HOLD_EN
  ,
  output logic [DATA_W-1:0] peak_out
`endif
);

  localparam int unsigned ACC_W   = DATA_W + LOG2_N;
  localparam int unsigned TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  avg_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              ovr_acc_q, ovr_acc_d;
  logic [DATA_W-1:0] avg_out_d;
  logic              overrange_d, avg_valid_d;
  logic              is_max, timer_load, timer_expired;

  assign sum    = acc_q + ACC_W'(sample_in);
  assign is_max = (sample_in == '1);

`ifdef AVG_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_acc_q, peak_acc_d, peak_out_d, peak_now;
  assign peak_now = (sample_in > peak_acc_q) ? sample_in : peak_acc_q;
`endif

  hold_timer #(.W(TIMER_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (TIMER_W'(HOLD_CYCLES - 1)),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovr_acc_q <= 1'b0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      overrange <= 1'b0;
`ifdef AVG_PEAK_HOLD_EN
      peak_acc_q <= '0;
      peak_out   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovr_acc_q <= ovr_acc_d;
      avg_out   <= avg_out_d;
      avg_valid <= avg_valid_d;
      overrange <= overrange_d;
`ifdef AVG_PEAK_HOLD_EN
      peak_acc_q <= peak_acc_d;
      peak_out   <= peak_out_d;
`endif
    end
  end

  // Window accumulation, completion publish (suppressed by freeze) and hold sequencing.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovr_acc_d   = ovr_acc_q;
    avg_out_d   = avg_out;
    overrange_d = overrange;
    avg_valid_d = 1'b0;
    timer_load  = 1'b0;
`ifdef AVG_PEAK_HOLD_EN
    peak_acc_d  = peak_acc_q;
    peak_out_d  = peak_out;
`endif
    case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          if (&cnt_q) begin
            acc_d      = '0;
            cnt_d      = '0;
            ovr_acc_d  = 1'b0;
            timer_load = 1'b1;
            state_d    = HOLD;
`ifdef AVG_PEAK_HOLD_EN
            peak_acc_d = '0;
`endif
            if (!freeze) begin
              avg_out_d   = DATA_W'(sum >> LOG2_N);
              overrange_d = ovr_acc_q | is_max;
              avg_valid_d = 1'b1;
`ifdef AVG_PEAK_HOLD_EN
              peak_out_d  = peak_now;
`endif
            end
          end else begin
            acc_d     = sum;
            cnt_d     = cnt_q + LOG2_N'(1);
            ovr_acc_d = ovr_acc_q | is_max;
`ifdef AVG_PEAK_HOLD_EN
            peak_acc_d = peak_now;
`endif
          end
        end
      end
      HOLD: begin
        if (timer_expired) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule
